fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 49 ++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory, redirect and decode handshake bundle for the fetch stage
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  modport master (
    output imem_req, imem_addr, id_valid, id_inst, id_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, br_taken, br_target, id_ready
  );
  modport slave (
    input  imem_req, imem_addr, id_valid, id_inst, id_pc,
    output imem_gnt, imem_rvalid, imem_rdata, br_taken, br_target, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with branch redirect and a one-entry decode register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst_n,
  fetch_stage_if.master bus
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;
  state_t      state, state_nx;
  logic [31:0] pc, req_pc;
  logic        fire, load;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_REQ;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      S_REQ:   state_nx = fire ? S_WAIT : S_REQ;
      S_WAIT:  state_nx = bus.imem_rvalid ? S_REQ : bus.br_taken ? S_DROP : S_WAIT;
      S_DROP:  state_nx = bus.imem_rvalid ? S_REQ : S_DROP;
      default: state_nx = S_REQ;
    endcase
  end
  // request is held off while reset is asserted so the bus is quiet until release
  always_comb begin
    bus.imem_req  = rst_n & (state == S_REQ) & (~bus.id_valid | bus.id_ready) & ~bus.br_taken;
    bus.imem_addr = pc;
    fire          = bus.imem_req & bus.imem_gnt;
    load          = (state == S_WAIT) & bus.imem_rvalid & ~bus.br_taken;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc           <= RESET_PC;
      req_pc       <= '0;
      bus.id_valid <= 1'b0;
      bus.id_inst  <= NOP_INST;
      bus.id_pc    <= '0;
    end else begin
      pc           <= bus.br_taken ? (bus.br_target & ~32'h3) : fire ? pc + 32'd4 : pc;
      bus.id_valid <= bus.br_taken ? 1'b0 : load ? 1'b1 : bus.id_valid & ~bus.id_ready;
      if (fire) req_pc <= pc;
      if (load) begin
        bus.id_inst <= bus.imem_rdata;
        bus.id_pc   <= req_pc;
      end
    end
endmodule
